// File: rtl/adder_sweep_checker.sv
// Exhaustive stimulus/response checker for a combinational WIDTH-bit full adder.
// Sweeps every {c_in, b, a} vector, compares against a golden sum, counts and captures mismatches.
module adder_sweep_checker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ERR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               c_in_out,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic               c_out_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               first_fail_valid,
    output logic [2*WIDTH:0]   first_fail_vec
);

    localparam int unsigned VW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [VW-1:0]     r_vec;
    logic [VW-1:0]     w_vec_next;
    logic [ERR_W-1:0]  r_err;
    logic [ERR_W-1:0]  w_err_next;
    logic              r_ff_valid;
    logic              w_ff_valid_next;
    logic [VW-1:0]     r_ff_vec;
    logic [VW-1:0]     w_ff_vec_next;

    logic [WIDTH:0]    w_exp;
    logic              w_mismatch;

    // Golden result from the registered operands, i.e. exactly what the adder sees.
    assign w_exp = {1'b0, r_vec[WIDTH-1:0]} + {1'b0, r_vec[2*WIDTH-1:WIDTH]}
                 + {{WIDTH{1'b0}}, r_vec[VW-1]};
    assign w_mismatch = ({c_out_in, sum_in} != w_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_vec      <= '0;
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_vec      <= w_vec_next;
            r_err      <= w_err_next;
            r_ff_valid <= w_ff_valid_next;
            r_ff_vec   <= w_ff_vec_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_vec_next      = r_vec;
        w_err_next      = r_err;
        w_ff_valid_next = r_ff_valid;
        w_ff_vec_next   = r_ff_vec;
        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_next    = StRun;
                    w_vec_next      = '0;
                    w_err_next      = '0;
                    w_ff_valid_next = 1'b0;
                    w_ff_vec_next   = '0;
                end
            end
            StRun: begin
                w_vec_next = r_vec + 1'b1;
                if (w_mismatch) begin
                    if (r_err != {ERR_W{1'b1}}) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (!r_ff_valid) begin
                        w_ff_valid_next = 1'b1;
                        w_ff_vec_next   = r_vec;
                    end
                end
                if (r_vec == {VW{1'b1}}) begin
                    w_state_next = StDone;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        a_out            = r_vec[WIDTH-1:0];
        b_out            = r_vec[2*WIDTH-1:WIDTH];
        c_in_out         = r_vec[VW-1];
        busy             = (r_state == StRun);
        done             = (r_state == StDone);
        pass             = (r_state == StDone) && (r_err == '0);
        err_count        = r_err;
        first_fail_valid = r_ff_valid;
        first_fail_vec   = r_ff_vec;
    end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: WIDTH=4 sweeps against a faultable adder model,
// one instance with a wide counter and one with an 8-bit saturating counter.
module tb_adder_sweep_checker;

    localparam int unsigned W  = 4;
    localparam int unsigned VW = 2 * W + 1;
    localparam int          N  = 1 << VW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   fault_mode = 0;

    logic [W-1:0]  a0, b0, s0, a1, b1, s1;
    logic          ci0, co0, ci1, co1;
    logic          busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
    logic [15:0]   err0;
    logic [7:0]    err1;
    logic [VW-1:0] ffvec0, ffvec1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int           fault;
        logic [15:0]  exp_err;
        logic [7:0]   exp_err_sat;
        logic         exp_ffv;
        logic [8:0]   exp_ffvec;
        logic         exp_pass;
    } vec_t;

    vec_t tbl[4];
    vec_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input int fault);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        case (fault)
            1: s[0] = 1'b0;
            2: s[W] = 1'b0;
            3: s[W-1:0] = ~s[W-1:0];
            default: ;
        endcase
        return s;
    endfunction

    always_comb {co0, s0} = adder(a0, b0, ci0, fault_mode);
    always_comb {co1, s1} = adder(a1, b1, ci1, fault_mode);

    adder_sweep_checker #(.WIDTH(W), .ERR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a0), .b_out(b0), .c_in_out(ci0),
        .sum_in(s0), .c_out_in(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    adder_sweep_checker #(.WIDTH(W), .ERR_W(8)) u_sat (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a1), .b_out(b1), .c_in_out(ci1),
        .sum_in(s1), .c_out_in(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a/b/c"}, {23'd0, ci0, b0, a0}, 32'd0);
        chk({tag, " flags"}, {26'd0, busy0, done0, pass0, busy1, done1, pass1}, 32'd0);
        chk({tag, " err"}, {8'd0, err0, err1}, 32'd0);
        chk({tag, " ff"}, {13'd0, ffv0, ffvec0, ffv1, ffvec1}, 32'd0);
    endtask

    // Start on the next edge, run until done (bounded), then score the results.
    task automatic run_sweep(input bit poke_mid);
        int         cyc;
        logic [8:0] k;
        vec_t       e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start busy", {31'd0, busy0}, 32'd1);
        chk("start done", {31'd0, done0}, 32'd0);
        chk("start vec", {23'd0, ci0, b0, a0}, 32'd0);
        chk("start clear", {15'd0, ffv0, err0}, 32'd0);
        cyc = 0;
        while (!done0 && cyc < N + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            k = cyc[8:0];
            if (cyc == 1 || cyc == 37 || cyc == 300) begin
                chk("sweep vec", {23'd0, ci0, b0, a0}, {23'd0, k});
            end
            if (poke_mid && cyc == 100) start = 1'b1;
            if (poke_mid && cyc == 101) start = 1'b0;
        end
        chk("done latency", cyc, N);
        chk("sat done", {31'd0, done1}, 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("err_count", {16'd0, err0}, {16'd0, e.exp_err});
            chk("err_count sat", {24'd0, err1}, {24'd0, e.exp_err_sat});
            chk("ff_valid", {31'd0, ffv0}, {31'd0, e.exp_ffv});
            chk("ff_vec", {23'd0, ffvec0}, {23'd0, e.exp_ffvec});
            chk("ff_vec sat", {23'd0, ffvec1}, {23'd0, e.exp_ffvec});
            chk("pass", {31'd0, pass0}, {31'd0, e.exp_pass});
            chk("pass sat", {31'd0, pass1}, {31'd0, e.exp_pass && e.exp_err_sat == 0});
            repeat (3) @(posedge clk);
            #1;
            chk("hold err", {16'd0, err0}, {16'd0, e.exp_err});
            chk("hold done", {30'd0, done0, busy0}, 32'd2);
        end
    endtask

    initial begin
        tbl[0] = '{fault: 0, exp_err: 16'd0,   exp_err_sat: 8'd0,   exp_ffv: 1'b0,
                   exp_ffvec: 9'h000, exp_pass: 1'b1};
        tbl[1] = '{fault: 1, exp_err: 16'd256, exp_err_sat: 8'd255, exp_ffv: 1'b1,
                   exp_ffvec: 9'h001, exp_pass: 1'b0};
        tbl[2] = '{fault: 2, exp_err: 16'd256, exp_err_sat: 8'd255, exp_ffv: 1'b1,
                   exp_ffvec: 9'h01F, exp_pass: 1'b0};
        tbl[3] = '{fault: 3, exp_err: 16'd512, exp_err_sat: 8'd255, exp_ffv: 1'b1,
                   exp_ffvec: 9'h000, exp_pass: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle busy", {31'd0, busy0}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            fault_mode = tbl[i].fault;
            sb.push_back(tbl[i]);
            run_sweep(1'b0);
        end

        // Restart from DONE with a clean adder; mid-run start must not disturb timing.
        fault_mode = 0;
        sb.push_back(tbl[0]);
        run_sweep(1'b1);

        // Reset mid-sweep, then a fresh sweep.
        fault_mode = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("mid rst");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post rst idle", {30'd0, busy0, done0}, 32'd0);
        fault_mode = 0;
        sb.push_back(tbl[0]);
        run_sweep(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Hardware self-checking exhaustive stimulus and response checker for a combinational WIDTH-bit full adder.
- Drives every operand/carry combination into the adder under test and samples its sum and carry-out.
- Compares each result against an internal golden model, counts mismatches, and captures the first failing vector.
- Sits beside the adder in on-board test builds, standing in for a simulation-only sweep bench; results go to LEDs or a status register.

## Interface
- WIDTH, 8, operand width of the adder under test
- ERR_W, 16, width of the mismatch counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep
- a_out  out  WIDTH  operand A to DUT (registered)
- b_out  out  WIDTH  operand B to DUT (registered)
- c_in_out  out  1  carry-in to DUT (registered)
- sum_in  in  WIDTH  DUT sum
- c_out_in  in  1  DUT carry-out
- busy  out  1  high while sweeping
- done  out  1  high once a sweep has completed; held until next start or rst
- pass  out  1  done && err_count == 0
- err_count  out  ERR_W  mismatch count, saturating
- first_fail_valid  out  1  a mismatch has been captured
- first_fail_vec  out  2*WIDTH+1  {c_in, b, a} of the first mismatch

## Operation
- Vector counter vec, 2*WIDTH+1 bits. Drives {c_in_out, b_out, a_out} = vec.
- Sweep order is all {b,a} with c_in=0, then all {b,a} with c_in=1. N = 2^(2*WIDTH+1) vectors (131072 for WIDTH=8).
- Golden model: {exp_cout, exp_sum} = a_out + b_out + c_in_out, computed at WIDTH+1 bits from the registered operands.
- Mismatch when {c_out_in, sum_in} != {exp_cout, exp_sum}.
- FSM states:
  - IDLE: busy=0. start → RUN; vec, err_count and first_fail are cleared.
  - RUN: busy=1. Every cycle compares the current vector, then increments vec. When the compared vector is N-1 → DONE; vec wraps to 0.
  - DONE: done=1, busy=0. start → RUN with full clear (restart).
- start in RUN is ignored.
- err_count increments by 1 per mismatch and saturates at 2^ERR_W-1; it never wraps.
- first_fail_vec/first_fail_valid load only on the first mismatch of a sweep. Later mismatches do not overwrite them.
- rst (any state, including mid-sweep): next edge sets state=IDLE and all outputs to 0 (a_out, b_out, c_in_out, busy, done, pass, err_count, first_fail_valid, first_fail_vec).

## Timing
- Edge E0 samples start in IDLE. After E0: busy=1, vector 0 is on the outputs.
- Each vector is presented for exactly one cycle. The DUT is purely combinational and must settle within one clock period.
- The compare for vector k uses sum_in/c_out_in sampled at the edge that replaces vector k with vector k+1. Counters update at that same edge.
- The final vector is compared at edge E0+N. After E0+N: busy=0, done=1, and pass is valid.
- Sweep latency is N cycles from the start edge to done.
- Result outputs (err_count, first_fail_*) remain stable in DONE.

## Test plan
- Correct adder, WIDTH=8, single start pulse:
  - done rises exactly 131072 cycles after the start edge.
  - pass=1, err_count=0, first_fail_valid=0.
  - a_out/b_out/c_in_out monitored on a few sample cycles equal the low 17 bits of the cycle index.
- DUT sum[0] stuck at 0 → err_count=65536, first_fail_vec=17'h00001, pass=0.
- DUT c_out stuck at 0 → err_count=65536 (32640 with c_in=0, 32896 with c_in=1), first_fail_vec=17'h001FF (b=1, a=255, c_in=0).
- ERR_W=8 with DUT sum inverted → err_count saturates at 255 and holds; first_fail_vec=17'h00000; done still arrives after 131072 cycles.
- rst asserted 1000 cycles into a sweep:
  - At the next edge all outputs are 0 and the FSM is IDLE.
  - A new start then runs a full 131072-cycle sweep with the correct adder, ending pass=1.
- start pulsed mid-RUN has no effect (done timing unchanged). start pulsed in DONE clears results and re-runs the sweep.
